// File: rtl/weight_update_engine.sv
// Hidden-to-output backpropagation engine: output deltas, back-propagated hidden
// deltas and in-place weight update, all sharing one signed multiplier.
module weight_update_engine #(
  parameter  int DW       = 10,
  parameter  int FRAC     = 8,
  parameter  int N_OUT    = 3,
  parameter  int N_HID    = 5,
  parameter  int LR_SHIFT = 3,
  localparam int AW       = $clog2(N_OUT * N_HID)
) (
  input  logic                   Clock,
  input  logic                   Rst,
  input  logic                   start,
  input  logic [N_OUT*DW-1:0]    out1_actual,
  input  logic [N_OUT*DW-1:0]    out1_cal,
  input  logic [N_HID*DW-1:0]    out0_cal,
  input  logic                   WE,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [N_OUT*DW-1:0]    delta1,
  output logic [N_HID*DW-1:0]    delta0,
  output logic                   busy,
  output logic                   done
);

  localparam int NW   = N_OUT * N_HID;
  localparam int ACCW = 2 * DW + $clog2(N_OUT);
  localparam int KW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int JW   = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int SH   = FRAC + LR_SHIFT;
  localparam logic signed [ACCW-1:0] SMAX = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_BACK, S_UPD, S_DONE} state_t;

  state_t                 r_state;
  logic signed [DW-1:0]   r_w   [NW];
  logic signed [DW-1:0]   r_act [N_OUT];
  logic signed [DW-1:0]   r_cal [N_OUT];
  logic signed [DW-1:0]   r_h   [N_HID];
  logic signed [DW-1:0]   r_d1  [N_OUT];
  logic signed [DW-1:0]   r_d0  [N_HID];
  logic signed [ACCW-1:0] r_acc [N_HID];
  logic [KW-1:0]          r_k;
  logic [JW-1:0]          r_j;
  logic [AW-1:0]          r_widx;

  logic signed [DW-1:0]   w_ma, w_mb;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_acc_add, w_upd_sum, w_diff;
  logic signed [ACCW-1:0] w_accv [N_HID];
  logic                   w_upd, w_last_j, w_last_k, w_last_w, w_addr_ok;

  function automatic logic signed [DW-1:0] f_sat(input logic signed [ACCW-1:0] v);
    if (v > SMAX)      f_sat = {1'b0, {(DW-1){1'b1}}};
    else if (v < SMIN) f_sat = {1'b1, {(DW-1){1'b0}}};
    else               f_sat = v[DW-1:0];
  endfunction

  // Single multiplier: w*delta1 while back-propagating, delta1*h while updating.
  assign w_upd     = (r_state == S_UPD);
  assign w_ma      = w_upd ? r_h[r_j] : r_w[r_widx];
  assign w_mb      = r_d1[r_k];
  assign w_prod    = (2*DW)'(w_ma) * (2*DW)'(w_mb);
  assign w_acc_add = r_acc[r_j] + ACCW'(w_prod);
  assign w_upd_sum = ACCW'(r_w[r_widx]) + ACCW'(w_prod >>> SH);
  assign w_diff    = ACCW'(r_act[r_k]) - ACCW'(r_cal[r_k]);
  assign w_last_j  = (r_j == JW'(N_HID - 1));
  assign w_last_k  = (r_k == KW'(N_OUT - 1));
  assign w_last_w  = (r_widx == AW'(NW - 1));
  assign w_addr_ok = ({1'b0, waddr} < (AW+1)'(NW));

  // Final hidden deltas must include the product being accumulated this cycle.
  always_comb begin
    for (int unsigned j = 0; j < N_HID; j++) w_accv[j] = r_acc[j];
    w_accv[r_j] = w_acc_add;
  end

  always_comb begin
    delta1 = '0;
    delta0 = '0;
    for (int unsigned k = 0; k < N_OUT; k++) delta1[k*DW +: DW] = r_d1[k];
    for (int unsigned j = 0; j < N_HID; j++) delta0[j*DW +: DW] = r_d0[j];
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_widx  <= '0;
      for (int unsigned i = 0; i < NW; i++) r_w[i] <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        r_act[k] <= '0;
        r_cal[k] <= '0;
        r_d1[k]  <= '0;
      end
      for (int unsigned j = 0; j < N_HID; j++) begin
        r_h[j]   <= '0;
        r_d0[j]  <= '0;
        r_acc[j] <= '0;
      end
    end else begin
      rdata <= w_addr_ok ? r_w[waddr] : '0;
      case (r_state)
        S_IDLE: begin
          if (WE && w_addr_ok) r_w[waddr] <= wdata;
          if (start) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
              r_act[k] <= out1_actual[k*DW +: DW];
              r_cal[k] <= out1_cal[k*DW +: DW];
            end
            for (int unsigned j = 0; j < N_HID; j++) begin
              r_h[j]   <= out0_cal[j*DW +: DW];
              r_acc[j] <= '0;
            end
            r_k     <= '0;
            r_j     <= '0;
            r_widx  <= '0;
            busy    <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          r_d1[r_k] <= f_sat(w_diff);
          if (w_last_k) begin
            r_k     <= '0;
            r_state <= S_BACK;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_BACK, S_UPD: begin
          if (w_upd) r_w[r_widx] <= f_sat(w_upd_sum);
          else       r_acc[r_j]  <= w_acc_add;
          r_widx <= r_widx + AW'(1);
          if (w_last_j) begin
            r_j <= '0;
            r_k <= r_k + KW'(1);
          end else begin
            r_j <= r_j + JW'(1);
          end
          if (w_last_w) begin
            r_widx <= '0;
            r_k    <= '0;
            r_j    <= '0;
            if (w_upd) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              for (int unsigned j = 0; j < N_HID; j++) r_d0[j] <= f_sat(w_accv[j] >>> FRAC);
              r_state <= S_UPD;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update_engine.sv
// Bench for weight_update_engine: directed vector table, handshake/reset
// sequences and randomized steps against an integer-arithmetic model.
module tb_weight_update_engine;
  localparam int DW = 10, FRAC = 8, N_OUT = 3, N_HID = 5, LR_SHIFT = 3;
  localparam int NW = N_OUT * N_HID;
  localparam int AW = 4;

  logic                 Clock, Rst, start, WE, busy, done;
  logic [N_OUT*DW-1:0]  out1_actual, out1_cal, delta1;
  logic [N_HID*DW-1:0]  out0_cal, delta0;
  logic [AW-1:0]        waddr;
  logic [DW-1:0]        wdata, rdata;

  weight_update_engine #(.DW(DW), .FRAC(FRAC), .N_OUT(N_OUT), .N_HID(N_HID), .LR_SHIFT(LR_SHIFT)) dut (
    .Clock(Clock), .Rst(Rst), .start(start),
    .out1_actual(out1_actual), .out1_cal(out1_cal), .out0_cal(out0_cal),
    .WE(WE), .waddr(waddr), .wdata(wdata), .rdata(rdata),
    .delta1(delta1), .delta0(delta0), .busy(busy), .done(done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0, n_fail = 0;
  int mw [NW];
  int t_act [N_OUT], t_cal [N_OUT], t_h [N_HID];
  int m_d1 [N_OUT], m_d0 [N_HID];

  // Uniform-weight, uniform-h step vectors; packed arrays list element 2 first.
  typedef struct packed {
    logic [N_OUT-1:0][DW-1:0] act;
    logic [N_OUT-1:0][DW-1:0] cal;
    logic [DW-1:0]            h;
    logic [DW-1:0]            w;
    logic [N_OUT-1:0][DW-1:0] d1;
    logic [DW-1:0]            d0;
    logic [N_OUT-1:0][DW-1:0] wn;
  } vec_t;
  vec_t tbl [4];

  function automatic int clamp(input longint v);
    if (v > 511)  return 511;
    if (v < -512) return -512;
    return int'(v);
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((q * b != a) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic void model_step();
    longint acc;
    for (int k = 0; k < N_OUT; k++) m_d1[k] = clamp(longint'(t_act[k]) - t_cal[k]);
    for (int j = 0; j < N_HID; j++) begin
      acc = 0;
      for (int k = 0; k < N_OUT; k++) acc += longint'(mw[k*N_HID + j]) * m_d1[k];
      m_d0[j] = clamp(floor_div(acc, 2 ** FRAC));
    end
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < N_HID; j++)
        mw[k*N_HID + j] = clamp(longint'(mw[k*N_HID + j]) +
                                floor_div(longint'(m_d1[k]) * t_h[j], 2 ** (FRAC + LR_SHIFT)));
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int d1_at(input int k);
    return int'($signed(delta1[k*DW +: DW]));
  endfunction

  function automatic int d0_at(input int j);
    return int'($signed(delta0[j*DW +: DW]));
  endfunction

  task automatic write_w(input int a, input int v);
    WE = 1'b1; waddr = AW'(a); wdata = DW'(v);
    @(posedge Clock); #1;
    WE = 1'b0;
  endtask

  task automatic read_w(input int a, output int v);
    waddr = AW'(a);
    @(posedge Clock); #1;
    v = int'($signed(rdata));
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N_OUT; k++) begin
      out1_actual[k*DW +: DW] = DW'(t_act[k]);
      out1_cal[k*DW +: DW]    = DW'(t_cal[k]);
    end
    for (int j = 0; j < N_HID; j++) out0_cal[j*DW +: DW] = DW'(t_h[j]);
  endtask

  task automatic check_model(input string tag);
    int v;
    for (int k = 0; k < N_OUT; k++) check($sformatf("%s_d1[%0d]", tag, k), d1_at(k), m_d1[k]);
    for (int j = 0; j < N_HID; j++) check($sformatf("%s_d0[%0d]", tag, j), d0_at(j), m_d0[j]);
    for (int a = 0; a < NW; a++) begin
      read_w(a, v);
      check($sformatf("%s_w[%0d]", tag, a), v, mw[a]);
    end
  endtask

  task automatic run_step(input bit co_we, input int co_addr, input int co_data, input int mid_we_cyc);
    int done_cyc;
    drive_inputs();
    start = 1'b1;
    if (co_we) begin WE = 1'b1; waddr = AW'(co_addr); wdata = DW'(co_data); end
    @(posedge Clock); #1;
    start = 1'b0; WE = 1'b0;
    check("busy_after_start", busy, 1);
    done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin done_cyc = c; break; end
      WE = (c == mid_we_cyc);
      if (WE) begin waddr = '0; wdata = 10'h1AB; end
      @(posedge Clock); #1;
    end
    WE = 1'b0;
    check("done_cycle", done_cyc, 34);
    @(posedge Clock); #1;
    check("busy_after_done", busy, 0);
    check("done_after_done", done, 0);
  endtask

  task automatic load_uniform(input int w);
    for (int a = 0; a < NW; a++) begin
      write_w(a, w);
      mw[a] = w;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int v, ndone, a0, d0v;
    tbl[0] = '{act: {10'h094, 10'h32C, 10'h1D2}, cal: {10'h0AA, 10'h00D, 10'h3CD},
               h: 10'd256, w: 10'd256, d1: {-10'sd22, -10'sd225, 10'sd511},
               d0: 10'd264, wn: {10'd253, 10'd227, 10'd319}};
    tbl[1] = '{act: {10'sd511, -10'sd512, 10'sd100}, cal: {-10'sd512, 10'sd511, -10'sd50},
               h: -10'sd256, w: -10'sd128, d1: {10'sd511, -10'sd512, 10'sd150},
               d0: -10'sd75, wn: {-10'sd192, -10'sd64, -10'sd147}};
    tbl[2] = '{act: {3{10'sd511}}, cal: {3{-10'sd512}}, h: 10'sd511, w: 10'sd511,
               d1: {3{10'sd511}}, d0: 10'sd511, wn: {3{10'sd511}}};
    tbl[3] = '{act: {3{-10'sd512}}, cal: {3{10'sd511}}, h: 10'sd511, w: 10'sd511,
               d1: {3{-10'sd512}}, d0: -10'sd512, wn: {3{10'sd383}}};

    Rst = 1'b0; start = 1'b0; WE = 1'b0; waddr = '0; wdata = '0;
    out1_actual = '0; out1_cal = '0; out0_cal = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_delta1", delta1, 0);
    check("rst_delta0", delta0, 0);
    Rst = 1'b1;
    @(posedge Clock); #1;
    for (int a = 0; a < NW; a++) begin
      read_w(a, v);
      check($sformatf("rst_w[%0d]", a), v, 0);
    end

    for (int a = 0; a < NW; a++) write_w(a, 'h100 + a);
    for (int a = 0; a < NW; a++) begin
      read_w(a, v);
      check($sformatf("load_w[%0d]", a), v, 'h100 + a);
    end
    write_w(15, 77);
    read_w(15, v);
    check("oob_read", v, 0);
    read_w(14, v);
    check("oob_no_alias", v, 'h10E);

    for (int r = 0; r < 4; r++) begin
      load_uniform(int'($signed(tbl[r].w)));
      for (int k = 0; k < N_OUT; k++) begin
        t_act[k] = int'($signed(tbl[r].act[k]));
        t_cal[k] = int'($signed(tbl[r].cal[k]));
      end
      for (int j = 0; j < N_HID; j++) t_h[j] = int'($signed(tbl[r].h));
      model_step();
      run_step(1'b0, 0, 0, -1);
      for (int k = 0; k < N_OUT; k++)
        check($sformatf("vec%0d_d1[%0d]", r, k), d1_at(k), int'($signed(tbl[r].d1[k])));
      for (int j = 0; j < N_HID; j++)
        check($sformatf("vec%0d_d0[%0d]", r, j), d0_at(j), int'($signed(tbl[r].d0)));
      for (int a = 0; a < NW; a++) begin
        read_w(a, v);
        check($sformatf("vec%0d_w[%0d]", r, a), v, int'($signed(tbl[r].wn[a / N_HID])));
      end
    end

    // Handshake: second start at edge 5 is dropped; deltas appear on schedule.
    load_uniform(256);
    for (int k = 0; k < N_OUT; k++) begin
      t_act[k] = int'($signed(tbl[0].act[k]));
      t_cal[k] = int'($signed(tbl[0].cal[k]));
    end
    for (int j = 0; j < N_HID; j++) t_h[j] = 256;
    model_step();
    drive_inputs();
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      check($sformatf("hs_busy_c%0d", c), busy, (c <= 34));
      if (done) begin
        ndone++;
        check("hs_done_cycle", c, 34);
      end
      if (c == 2)  check("hs_d1_0_at_c2", d1_at(0), m_d1[0]);
      if (c == 19) check("hs_d0_0_at_c19", d0_at(0), m_d0[0]);
      start = (c == 5);
      @(posedge Clock); #1;
    end
    start = 1'b0;
    check("hs_done_count", ndone, 1);
    check_model("hs");

    for (int s = 0; s < 6; s++) begin
      bit co_we;
      int co_a, co_d, mid;
      if (s == 0)
        for (int a = 0; a < NW; a++) begin
          mw[a] = int'($urandom_range(0, 1023)) - 512;
          write_w(a, mw[a]);
        end
      for (int k = 0; k < N_OUT; k++) begin
        t_act[k] = int'($urandom_range(0, 1023)) - 512;
        t_cal[k] = int'($urandom_range(0, 1023)) - 512;
      end
      for (int j = 0; j < N_HID; j++) t_h[j] = int'($urandom_range(0, 1023)) - 512;
      co_we = (s == 2);
      co_a  = int'($urandom_range(0, NW - 1));
      co_d  = int'($urandom_range(0, 1023)) - 512;
      mid   = (s == 3) ? 10 : -1;
      if (co_we) mw[co_a] = co_d;
      model_step();
      run_step(co_we, co_a, co_d, mid);
      check_model($sformatf("rnd%0d", s));
    end

    // Mid-step reset at edge 12, then a clean step from zeroed weights.
    a0 = 0;
    for (int a = NW - 1; a >= 0; a--) if (mw[a] != 0) a0 = a;
    waddr = AW'(a0);
    for (int k = 0; k < N_OUT; k++) begin
      t_act[k] = int'($urandom_range(0, 1023)) - 512;
      t_cal[k] = int'($urandom_range(0, 1023)) - 512;
    end
    for (int j = 0; j < N_HID; j++) t_h[j] = int'($urandom_range(0, 1023)) - 512;
    drive_inputs();
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (12) @(posedge Clock);
    #1;
    Rst = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_rdata", rdata, 0);
    check("mrst_delta1", delta1, 0);
    check("mrst_delta0", delta0, 0);
    #3;
    Rst = 1'b1;
    for (int a = 0; a < NW; a++) mw[a] = 0;
    @(posedge Clock); #1;
    for (int a = 0; a < NW; a++) begin
      read_w(a, v);
      check($sformatf("mrst_w[%0d]", a), v, 0);
    end
    d0v = 0;
    model_step();
    run_step(1'b0, 0, 0, -1);
    check_model("post_rst");
    check("post_rst_d0_zero", d0_at(0), d0v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
